// File: rtl/bsg_id_pool_reorder_return_if.sv
// Handshake bundle between the ID pool, the tagging client and the response consumer.
// The reorder block sits on the slave side; the pool/client/consumer drive the master side.
interface bsg_id_pool_reorder_return_if #(
  parameter int els_p     = 32,
  parameter int width_p   = 32,
  parameter int lg_els_lp = (els_p == 1) ? 1 : $clog2(els_p)
);
  logic                 pool_v_i;
  logic [lg_els_lp-1:0] pool_id_i;
  logic                 pool_yumi_o;

  logic                 tag_v_o;
  logic [lg_els_lp-1:0] tag_id_o;
  logic                 tag_yumi_i;

  logic                 resp_v_i;
  logic [lg_els_lp-1:0] resp_id_i;
  logic [width_p-1:0]   resp_data_i;

  logic                 data_v_o;
  logic [lg_els_lp-1:0] data_id_o;
  logic [width_p-1:0]   data_o;
  logic                 data_yumi_i;

  logic                 dealloc_v_o;
  logic [lg_els_lp-1:0] dealloc_id_o;

  modport slave (
    input  pool_v_i, pool_id_i, tag_yumi_i, resp_v_i, resp_id_i, resp_data_i, data_yumi_i,
    output pool_yumi_o, tag_v_o, tag_id_o, data_v_o, data_id_o, data_o, dealloc_v_o, dealloc_id_o
  );

  modport master (
    output pool_v_i, pool_id_i, tag_yumi_i, resp_v_i, resp_id_i, resp_data_i, data_yumi_i,
    input  pool_yumi_o, tag_v_o, tag_id_o, data_v_o, data_id_o, data_o, dealloc_v_o, dealloc_id_o
  );
endinterface

// File: rtl/bsg_id_pool_reorder_return.sv
// Hands pool IDs to a client, buffers out-of-order responses and releases them in allocation order.
// Optional same-cycle head bypass: define BSG_ID_POOL_REORDER_BYPASS_EN.
module bsg_id_pool_reorder_return #(
  parameter int els_p   = 32,
  parameter int width_p = 32
) (
  input  logic clk,
  input  logic reset,
  bsg_id_pool_reorder_return_if.slave io
);
  localparam int lg_els_lp = (els_p == 1) ? 1 : $clog2(els_p);
  localparam int cnt_w_lp  = $clog2(els_p + 1);

  typedef logic [lg_els_lp-1:0] id_t;
  typedef logic [cnt_w_lp-1:0]  cnt_t;

  id_t                r_order [els_p];
  logic [width_p-1:0] r_data  [els_p];

  id_t                r_head, r_tail, r_dealloc_id;
  cnt_t               r_count, w_count_n;
  logic [els_p-1:0]   r_valid, w_valid_n;
  logic [els_p-1:0]   r_outst, w_outst_n;
  logic               r_dealloc_v;

  id_t                w_head_id;
  logic               w_empty, w_full, w_push, w_pop, w_bypass;

  function automatic id_t f_inc(input id_t p);
    return (p == id_t'(els_p - 1)) ? '0 : id_t'(p + id_t'(1));
  endfunction

  assign w_head_id = r_order[r_head];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == cnt_t'(els_p));
  assign w_push    = io.tag_yumi_i;
  assign w_pop     = io.data_yumi_i;

`ifdef BSG_ID_POOL_REORDER_BYPASS_EN
  assign w_bypass = io.resp_v_i & (io.resp_id_i == w_head_id) & ~w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign io.tag_v_o      = io.pool_v_i & ~w_full;
  assign io.tag_id_o     = io.pool_id_i;
  assign io.pool_yumi_o  = io.tag_yumi_i;

  assign io.data_v_o     = ~w_empty & (r_valid[w_head_id] | w_bypass);
  assign io.data_id_o    = w_head_id;
  assign io.data_o       = w_bypass ? io.resp_data_i : r_data[w_head_id];

  assign io.dealloc_v_o  = r_dealloc_v;
  assign io.dealloc_id_o = r_dealloc_id;

  always_comb begin
    w_count_n = r_count;
    if (w_push & ~w_pop)      w_count_n = r_count + cnt_t'(1);
    else if (~w_push & w_pop) w_count_n = r_count - cnt_t'(1);
  end

  // A bypassed head consumed in the same cycle never lands in the valid array.
  always_comb begin
    w_valid_n = r_valid;
    if (w_pop) w_valid_n[w_head_id] = 1'b0;
    if (io.resp_v_i & ~(w_bypass & w_pop)) w_valid_n[io.resp_id_i] = 1'b1;
  end

  always_comb begin
    w_outst_n = r_outst;
    if (w_pop)  w_outst_n[w_head_id]    = 1'b0;
    if (w_push) w_outst_n[io.pool_id_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_valid      <= '0;
      r_outst      <= '0;
      r_dealloc_v  <= 1'b0;
      r_dealloc_id <= '0;
    end else begin
      r_count     <= w_count_n;
      r_valid     <= w_valid_n;
      r_outst     <= w_outst_n;
      r_dealloc_v <= w_pop;
      if (w_push) r_tail <= f_inc(r_tail);
      if (w_pop) begin
        r_head       <= f_inc(r_head);
        r_dealloc_id <= w_head_id;
      end
    end
  end

  // Storage arrays are qualified by count/valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_push)      r_order[r_tail]      <= io.pool_id_i;
    if (io.resp_v_i) r_data[io.resp_id_i] <= io.resp_data_i;
  end

  a_tag_yumi: assert property (@(posedge clk) disable iff (!reset)
    io.tag_yumi_i |-> io.tag_v_o);
  a_data_yumi: assert property (@(posedge clk) disable iff (!reset)
    io.data_yumi_i |-> io.data_v_o);
  a_resp_legal: assert property (@(posedge clk) disable iff (!reset)
    io.resp_v_i |-> (r_outst[io.resp_id_i] & ~r_valid[io.resp_id_i]));
endmodule
